// File: rtl/reg_wb_ctrl.sv
// Register-file writeback controller: arbitrates ALU/mem results into a FIFO and keeps per-register pending-write counters.
// Optional same-cycle bypass into an empty FIFO when WB_BYPASS_EN is defined.
module reg_wb_ctrl #(
  parameter int DEPTH  = 4,
  parameter int PEND_W = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_alu_valid,
  output logic                     o_alu_ready,
  input  logic [4:0]               i_alu_rd,
  input  logic [31:0]              i_alu_data,
  input  logic                     i_mem_valid,
  output logic                     o_mem_ready,
  input  logic [4:0]               i_mem_rd,
  input  logic [31:0]              i_mem_data,
  input  logic                     i_wb_stall,
  input  logic                     i_issue_valid,
  input  logic [4:0]               i_issue_rd,
  output logic                     o_issue_ready,
  output logic [4:0]               o_WA,
  output logic [31:0]              o_WD,
  output logic                     o_WE,
  output logic [31:0]              o_busy,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [4:0]        rd_q   [DEPTH];
  logic [4:0]        rd_d   [DEPTH];
  logic [31:0]       data_q [DEPTH];
  logic [31:0]       data_d [DEPTH];
  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PEND_W-1:0] cnt_q  [32];
  logic [PEND_W-1:0] cnt_d  [32];

  logic        empty, full, mem_hs, alu_hs, hs, push, pop, byp, issue_inc;
  logic [4:0]  in_rd;
  logic [31:0] in_data;

  assign empty       = (count_q == '0);
  assign full        = (count_q == CW'(DEPTH));
  // Ready looks only at occupancy, so a full FIFO refuses input even while popping.
  assign o_mem_ready = !full;
  assign o_alu_ready = !full && !i_mem_valid;
  assign mem_hs      = i_mem_valid && o_mem_ready;
  assign alu_hs      = i_alu_valid && o_alu_ready;
  assign hs          = mem_hs || alu_hs;
  assign in_rd       = mem_hs ? i_mem_rd   : i_alu_rd;
  assign in_data     = mem_hs ? i_mem_data : i_alu_data;

`ifdef WB_BYPASS_EN
  assign byp = empty && !i_wb_stall && hs && (in_rd != 5'd0);
`else
  assign byp = 1'b0;
`endif

  assign push    = hs && (in_rd != 5'd0) && !byp;
  assign pop     = !empty && !i_wb_stall;
  assign o_count = count_q;

  always_comb begin
    o_WE = pop || byp;
    o_WA = '0;
    o_WD = '0;
    if (pop) begin
      o_WA = rd_q[rptr_q];
      o_WD = data_q[rptr_q];
    end else if (byp) begin
      o_WA = in_rd;
      o_WD = in_data;
    end
  end

  assign o_issue_ready = (i_issue_rd == 5'd0) || (cnt_q[i_issue_rd] != CNT_MAX);
  assign issue_inc     = i_issue_valid && o_issue_ready && (i_issue_rd != 5'd0);

  always_comb begin
    rd_d    = rd_q;
    data_d  = data_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + CW'(push) - CW'(pop);
    if (push) begin
      rd_d[wptr_q]   = in_rd;
      data_d[wptr_q] = in_data;
      wptr_d         = wptr_q + 1'b1;
    end
    if (pop) rptr_d = rptr_q + 1'b1;
    // Issue and retire on the same register cancel; a retire at zero holds.
    for (int r = 0; r < 32; r++) begin
      cnt_d[r] = cnt_q[r];
      if (issue_inc && i_issue_rd == 5'(r) && !(o_WE && o_WA == 5'(r)))
        cnt_d[r] = cnt_q[r] + 1'b1;
      else if (o_WE && o_WA == 5'(r) && !(issue_inc && i_issue_rd == 5'(r)) && cnt_q[r] != '0)
        cnt_d[r] = cnt_q[r] - 1'b1;
    end
  end

  always_comb begin
    o_busy = '0;
    for (int r = 1; r < 32; r++) o_busy[r] = (cnt_q[r] != '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
      for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  a_no_underflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    o_WE |-> (cnt_q[o_WA] != '0));

endmodule

// File: doc/reg_wb_ctrl.md
Name: reg_wb_ctrl

Overview:
- Writeback controller that drives the register file write port (write address, write data, write enable).
- Accepts completed results from two producers, the single-cycle ALU path and the multi-cycle load/multiply path, via valid/ready handshakes.
- Buffers results in a small FIFO and retires one per cycle.
- Keeps a per-register pending-write scoreboard that decode uses for hazard checks.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- PEND_W, 2, width of each per-register pending-write counter.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_alu_valid  in  1  ALU result valid.
- o_alu_ready  out  1  ALU result accepted this cycle.
- i_alu_rd  in  5  ALU destination register.
- i_alu_data  in  32  ALU result.
- i_mem_valid  in  1  load/multiply result valid.
- o_mem_ready  out  1  load/multiply result accepted this cycle.
- i_mem_rd  in  5  load/multiply destination register.
- i_mem_data  in  32  load/multiply result.
- i_wb_stall  in  1  register file write port unavailable; hold the FIFO head.
- i_issue_valid  in  1  decode issuing an instruction that writes i_issue_rd.
- i_issue_rd  in  5  destination register of the issuing instruction.
- o_issue_ready  out  1  pending counter for i_issue_rd is not saturated.
- o_WA  out  5  write address to the register file.
- o_WD  out  32  write data to the register file.
- o_WE  out  1  write enable to the register file.
- o_busy  out  32  bit r set when register r has at least one pending write.
- o_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, i_rst_n=0):
  - FIFO empty; pointers and o_count = 0.
  - All pending counters = 0, so o_busy = 0.
  - o_WE=0, o_WA=0, o_WD=0.
- Arbitration:
  - Mem has fixed priority over ALU.
  - o_mem_ready = (count<DEPTH).
  - o_alu_ready = (count<DEPTH) && !i_mem_valid.
  - At most one enqueue per cycle.
- Enqueue:
  - On a valid && ready handshake, push {rd,data} at the tail.
  - Results with rd=0 are accepted (ready honoured) but not stored; count is unchanged.
- Output drive:
  - o_WE, o_WA and o_WD are driven combinationally from the FIFO head.
  - o_WE = !empty && !i_wb_stall; o_WA and o_WD show the head entry.
  - When the FIFO is empty, o_WA and o_WD hold 0.
- Dequeue:
  - Pop at the edge when o_WE=1.
  - Base latency: a handshake at edge N appears on o_WE in cycle N+1, provided the FIFO was empty and there is no stall.
- Full FIFO with simultaneous pop:
  - Ready is computed from count only, not count minus pop.
  - A full FIFO refuses input even in a cycle where it pops.
- Simultaneous push and pop:
  - Both take effect; count is unchanged.
  - Pointers wrap modulo DEPTH.
- Scoreboard:
  - Issue: on i_issue_valid && o_issue_ready && i_issue_rd!=0, cnt[rd] increments.
  - Retire: on o_WE, cnt[o_WA] decrements.
  - Same register, issue and retire in the same cycle: net unchanged.
  - o_busy[r] = (cnt[r]!=0); o_busy[0] is always 0.
  - o_issue_ready = (cnt[i_issue_rd] != 2^PEND_W-1), and is always 1 for rd=0.
  - Decode must stall while o_issue_ready=0.
- Ordering: retirement order equals acceptance order; no write to a given register is reordered.
- Reset mid-operation: FIFO contents are discarded, all counters clear, and o_WE drops immediately (async).
- Underflow guard: a retire against cnt=0 is a protocol error. The counter holds at 0; checked by a simulation assertion.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: when the FIFO is empty, i_wb_stall=0 and a handshake occurs (rd!=0), that result drives o_WE/o_WA/o_WD in the same cycle and is not enqueued.
  - Zero-cycle latency.
  - The scoreboard decrements in that cycle.
- Undefined: every result passes through the FIFO, with a minimum latency of 1 cycle.

Test Plan:
- Reset, then ALU valid with rd=5 and data=0x0000_00AA at edge 1 -> o_WE=1, o_WA=5, o_WD=0xAA in cycle 2; o_count returns to 0 after edge 2.
- i_alu_valid and i_mem_valid both high, rd 3 and rd 4 -> o_mem_ready=1 and o_alu_ready=0; rd 4 retires first and rd 3 the cycle after.
- Hold i_wb_stall=1 and push 4 results -> o_count=4, both readys 0, a fifth push is refused; release the stall -> 4 writes in order on consecutive cycles.
- Push rd=0 with data 0xDEAD -> accepted, o_count stays 0, o_WE never asserts.
- Issue rd=7 three times (PEND_W=2) -> o_busy[7]=1 and o_issue_ready=0 at cnt=3; after three retires to rd 7, o_busy[7]=0.
- Assert i_rst_n=0 with 2 entries queued and o_busy[9]=1 -> o_WE=0, o_count=0, o_busy=0 immediately; with WB_BYPASS_EN, a push into an empty FIFO shows o_WE in the same cycle.
